// File: rtl/crc_lut_pkg.sv
// Shared types and CRC helpers for the self-initialising CRC lookup table.
// Helpers work on 64-bit containers so one function set covers CRC_W 8..64.
package crc_lut_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_POLY_NORM = 32'h04C11DB7;

    function automatic logic [63:0] width_mask(input int unsigned crc_w);
        if (crc_w >= 64)
            return '1;
        return (64'd1 << crc_w) - 64'd1;
    endfunction

    // One shift iteration of the CRC register with zero input bit.
    function automatic logic [63:0] crc_step(
        input logic [63:0] c,
        input logic [63:0] poly,
        input logic        reflect,
        input int unsigned crc_w
    );
        logic [63:0] r;
        if (reflect)
            r = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        else
            r = c[crc_w-1] ? ((c << 1) ^ poly) : (c << 1);
        return r & width_mask(crc_w);
    endfunction

    function automatic logic [63:0] seed(
        input logic [63:0] idx,
        input logic        reflect,
        input int unsigned crc_w,
        input int unsigned entry_bits
    );
        logic [63:0] r;
        if (reflect)
            r = idx;
        else
            r = idx << (crc_w - entry_bits);
        return r & width_mask(crc_w);
    endfunction

endpackage

// File: rtl/crc_lut_ram.sv
// Table storage: one write port, one registered read port.
// The read register resets to zero; the array itself is not reset.
module crc_lut_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/crc_lut_gen.sv
// Self-initialising CRC lookup table: builds every entry after reset/rebuild.
// Optional per-entry even parity is enabled by defining CRC_LUT_GEN_PARITY_EN.
//
// state | meaning
// IDLE  | reserved; falls back to LOAD with idx 0
// LOAD  | seed the CRC register from idx, arm the shift counter
// SHIFT | apply BITS_PER_CYC zero-bit iterations per cycle
// WRITE | store the finished entry, advance idx or finish
// DONE  | table complete, reads accepted
module crc_lut_gen
    import crc_lut_pkg::*;
#(
    parameter int               CRC_W        = 32,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(CRC32_POLY_REFL),
    parameter bit               REFLECT      = 1'b1,
    parameter int               ENTRY_BITS   = 8,
    parameter int               STAGE        = 0,
    parameter int               BITS_PER_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rebuild,
    output logic                  ready,
    input  logic                  rd_en,
    input  logic [ENTRY_BITS-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [CRC_W-1:0]      rd_data,
    output logic                  rd_perr
);

    localparam int DEPTH   = 2 ** ENTRY_BITS;
    localparam int N_ITER  = ENTRY_BITS * (STAGE + 1);
    localparam int STEPS   = N_ITER / BITS_PER_CYC;
    localparam int CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [ENTRY_BITS-1:0] IDX_LAST = '1;
    localparam logic [63:0] POLY_W = 64'(POLY);
`ifdef CRC_LUT_GEN_PARITY_EN
    localparam int RAM_W = CRC_W + 1;
`else
    localparam int RAM_W = CRC_W;
`endif

    if ((N_ITER % BITS_PER_CYC) != 0) begin : g_bad_bpc
        $error("BITS_PER_CYC must divide ENTRY_BITS*(STAGE+1)");
    end

    state_t                state, state_next;
    logic [ENTRY_BITS-1:0] idx, idx_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [CRC_W-1:0]      crc, crc_next, crc_adv;
    logic [63:0]           crc_wide;
    logic                  we;
    logic                  rd_accept;
    logic [RAM_W-1:0]      wdata, rword;

    always_comb begin
        crc_wide = 64'(crc);
        for (int i = 0; i < BITS_PER_CYC; i++)
            crc_wide = crc_step(crc_wide, POLY_W, REFLECT, CRC_W);
        crc_adv = CRC_W'(crc_wide);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            idx   <= '0;
            cnt   <= '0;
            crc   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
            crc   <= crc_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        crc_next   = crc;
        we         = 1'b0;
        case (state)
            LOAD: begin
                crc_next   = CRC_W'(seed(64'(idx), REFLECT, CRC_W, ENTRY_BITS));
                cnt_next   = CNT_W'(STEPS - 1);
                state_next = SHIFT;
            end
            SHIFT: begin
                crc_next = crc_adv;
                if (cnt == '0)
                    state_next = WRITE;
                else
                    cnt_next = cnt - 1'b1;
            end
            WRITE: begin
                we = 1'b1;
                if (idx == IDX_LAST) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = LOAD;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = LOAD;
                idx_next   = '0;
            end
        endcase
        // A rebuild overrides whatever the FSM was doing, including a write.
        if (rebuild) begin
            we         = 1'b0;
            state_next = LOAD;
            idx_next   = '0;
        end
    end

    assign ready     = (state == DONE);
    assign rd_accept = rd_en && ready && !rebuild;

    always_ff @(posedge clk) begin
        if (rst)
            rd_valid <= 1'b0;
        else
            rd_valid <= rd_accept;
    end

`ifdef CRC_LUT_GEN_PARITY_EN
    assign wdata   = {^crc, crc};
    assign rd_data = rword[CRC_W-1:0];
    assign rd_perr = rd_valid && (^rword);
`else
    assign wdata   = crc;
    assign rd_data = rword;
    assign rd_perr = 1'b0;
`endif

    crc_lut_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ENTRY_BITS),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (idx),
        .wdata  (wdata),
        .re     (rd_accept),
        .raddr  (rd_addr),
        .rdata  (rword)
    );

endmodule

// File: tb/tb_crc_lut_gen.sv
// Directed bench for crc_lut_gen: default reflected CRC-32, MSB-first CRC-32,
// and a STAGE=19 / 8-bits-per-cycle instance built side by side.
module tb_crc_lut_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rebuild_d, rd_en_d, ready_d, rd_valid_d, rd_perr_d;
    logic [7:0]  rd_addr_d;
    logic [31:0] rd_data_d;
    logic        rebuild_n, rd_en_n, ready_n, rd_valid_n, rd_perr_n;
    logic [7:0]  rd_addr_n;
    logic [31:0] rd_data_n;
    logic        rebuild_s, rd_en_s, ready_s, rd_valid_s, rd_perr_s;
    logic [7:0]  rd_addr_s;
    logic [31:0] rd_data_s;

    crc_lut_gen dut (
        .clk(clk), .rst(rst), .rebuild(rebuild_d), .ready(ready_d),
        .rd_en(rd_en_d), .rd_addr(rd_addr_d), .rd_valid(rd_valid_d),
        .rd_data(rd_data_d), .rd_perr(rd_perr_d)
    );

    crc_lut_gen #(.CRC_W(32), .POLY(32'h04C11DB7), .REFLECT(1'b0)) dut_n (
        .clk(clk), .rst(rst), .rebuild(rebuild_n), .ready(ready_n),
        .rd_en(rd_en_n), .rd_addr(rd_addr_n), .rd_valid(rd_valid_n),
        .rd_data(rd_data_n), .rd_perr(rd_perr_n)
    );

    crc_lut_gen #(.CRC_W(32), .POLY(32'hEDB88320), .REFLECT(1'b1),
                  .STAGE(19), .BITS_PER_CYC(8)) dut_s (
        .clk(clk), .rst(rst), .rebuild(rebuild_s), .ready(ready_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_valid(rd_valid_s),
        .rd_data(rd_data_s), .rd_perr(rd_perr_s)
    );

    // Cycle count since reset release; used to time the slower instances.
    int cyc = 0;
    int t_norm = 0;
    int t_stage = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end
    always @(posedge clk) begin
        #1;
        if (!rst && ready_n && t_norm == 0) t_norm = cyc;
        if (!rst && ready_s && t_stage == 0) t_stage = cyc;
    end

    function automatic logic [31:0] model(input logic [7:0] idx, input logic [31:0] poly,
                                          input bit refl, input int n);
        logic [31:0] c;
        c = refl ? {24'd0, idx} : {idx, 24'd0};
        for (int i = 0; i < n; i++) begin
            if (refl) c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
            else      c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single read on the default instance; result sampled one cycle later.
    task automatic read_d(input logic [7:0] a);
        rd_en_d = 1'b1; rd_addr_d = a;
        @(posedge clk); #1;
        rd_en_d = 1'b0;
    endtask

    task automatic read_n(input logic [7:0] a);
        rd_en_n = 1'b1; rd_addr_n = a;
        @(posedge clk); #1;
        rd_en_n = 1'b0;
    endtask

    logic [31:0] s_tab [256];
    logic [31:0] exp_v;
    logic        flip_bit;
    int n;
    int early;

    initial begin
        rebuild_d = 0; rd_en_d = 1; rd_addr_d = 8'h00;
        rebuild_n = 0; rd_en_n = 0; rd_addr_n = 8'h00;
        rebuild_s = 0; rd_en_s = 0; rd_addr_s = 8'h00;
        flip_bit = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, ready_d}, 64'd0);
        chk("rst_outputs", {rd_valid_d, rd_perr_d, rd_data_d}, 64'd0);

        @(negedge clk);
        rst = 1'b0;

        // rd_en held high throughout the build: no valid until ready.
        n = 0; early = 0;
        while (!ready_d && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (rd_valid_d) early++;
        end
        chk("build_time", 64'(n), 64'd2560);
        chk("early_valid", 64'(early), 64'd0);

        for (int a = 0; a < 256; a++) begin
            rd_addr_d = 8'(a);
            @(posedge clk); #1;
            exp_v = model(8'(a), 32'hEDB88320, 1'b1, 8);
            chk("b2b_read", {31'd0, rd_valid_d, rd_data_d}, {31'd0, 1'b1, exp_v});
        end
        rd_en_d = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", {31'd0, rd_valid_d, rd_data_d}, {31'd0, 1'b0, 32'h2D02EF8D});

        read_d(8'h01);
        chk("refl_01", {30'd0, rd_perr_d, rd_valid_d, rd_data_d}, {30'd0, 1'b0, 1'b1, 32'h77073096});
        read_d(8'h80);
        chk("refl_80", {30'd0, rd_perr_d, rd_valid_d, rd_data_d}, {30'd0, 1'b0, 1'b1, 32'hEDB88320});
        read_d(8'hFF);
        chk("refl_FF", {30'd0, rd_perr_d, rd_valid_d, rd_data_d}, {30'd0, 1'b0, 1'b1, 32'h2D02EF8D});

        n = 0;
        while (t_stage == 0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("norm_build_time", 64'(t_norm), 64'd2560);
        chk("stage_build_time", 64'(t_stage), 64'd5632);

        read_n(8'h01);
        chk("norm_01", {31'd0, rd_valid_n, rd_data_n}, {31'd0, 1'b1, 32'h04C11DB7});
        read_n(8'h02);
        chk("norm_02", {31'd0, rd_valid_n, rd_data_n}, {31'd0, 1'b1, 32'h09823B6E});

        rd_en_s = 1'b1;
        for (int a = 0; a < 256; a++) begin
            rd_addr_s = 8'(a);
            @(posedge clk); #1;
            s_tab[a] = rd_data_s;
            exp_v = model(8'(a), 32'hEDB88320, 1'b1, 160);
            chk("stage_entry", {31'd0, rd_valid_s, rd_data_s}, {31'd0, 1'b1, exp_v});
        end
        rd_en_s = 1'b0;
        chk("stage_linear", {32'd0, s_tab[3]}, {32'd0, s_tab[1] ^ s_tab[2]});

        // Rebuild in DONE together with a read: read dropped, ready falls.
        rebuild_d = 1'b1; rd_en_d = 1'b1; rd_addr_d = 8'h01;
        @(posedge clk); #1;
        rebuild_d = 1'b0; rd_en_d = 1'b0;
        chk("rebuild_ready_low", {63'd0, ready_d}, 64'd0);
        chk("rebuild_read_dropped", {63'd0, rd_valid_d}, 64'd0);

        // Second rebuild while entry 100 is being generated.
        repeat (1004) @(posedge clk);
        #1;
        rebuild_d = 1'b1;
        @(posedge clk); #1;
        rebuild_d = 1'b0;
        chk("midbuild_not_ready", {63'd0, ready_d}, 64'd0);
        n = 0;
        while (!ready_d && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rebuild_time", 64'(n), 64'd2560);
        read_d(8'hFF);
        chk("rebuilt_FF", {30'd0, rd_perr_d, rd_valid_d, rd_data_d}, {30'd0, 1'b0, 1'b1, 32'h2D02EF8D});

`ifdef CRC_LUT_GEN_PARITY_EN
        exp_v = model(8'h55, 32'hEDB88320, 1'b1, 8);
        flip_bit = ~exp_v[0];
        force dut.u_ram.mem[8'h55][0] = flip_bit;
        read_d(8'h55);
        chk("parity_err", {62'd0, rd_perr_d, rd_valid_d}, {62'd0, 1'b1, 1'b1});
        release dut.u_ram.mem[8'h55][0];
`else
        read_d(8'h55);
        exp_v = model(8'h55, 32'hEDB88320, 1'b1, 8);
        chk("no_parity_55", {30'd0, rd_perr_d, rd_valid_d, rd_data_d}, {30'd0, 1'b0, 1'b1, exp_v});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_lut_gen.md
Name: crc_lut_gen

Overview:
- Parametrised, self-initialising CRC lookup table for the pipelined LUT CRC datapath.
- Replaces hand-listed constant ROMs: after reset, it computes every entry in hardware for the configured polynomial, bit order and stage offset (number of zero bytes the table advances).
- Serves registered reads with a valid handshake.
- One instance per pipeline stage; STAGE selects the stage.

Parameters:
- CRC_W, 32, CRC width in bits (8..64).
- POLY, 32'hEDB88320, generator polynomial in the bit order given by REFLECT.
- REFLECT, 1, 1 = LSB-first (shift right), 0 = MSB-first (shift left).
- ENTRY_BITS, 8, index width; depth = 2**ENTRY_BITS.
- STAGE, 0, extra zero chunks (ENTRY_BITS bits each) the table advances.
- BITS_PER_CYC, 1, unrolled shift iterations per clock; must divide ENTRY_BITS*(STAGE+1).

Ports:
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- rebuild, in, 1, single-cycle pulse that restarts table generation.
- ready, out, 1, high when the table is fully built.
- rd_en, in, 1, read request; accepted only when ready=1.
- rd_addr, in, ENTRY_BITS, read index.
- rd_valid, out, 1, read data valid, one cycle after an accepted rd_en.
- rd_data, out, CRC_W, table entry.
- rd_perr, out, 1, parity error on the returned entry; tied 0 when the optional feature is absent.

Behaviour:
- Entry definition, iterated N = ENTRY_BITS*(STAGE+1) times:
  - REFLECT=1: start c = idx (zero-extended); each iteration c = c[0] ? (c>>1)^POLY : c>>1.
  - REFLECT=0: start c = idx << (CRC_W-ENTRY_BITS); each iteration c = c[CRC_W-1] ? (c<<1)^POLY : c<<1 (truncated to CRC_W).
- No init value or final XOR; the table is linear: T[a^b] = T[a]^T[b].
- FSM states IDLE, LOAD, SHIFT, WRITE, DONE:
  - rst: state LOAD, idx=0, ready=0, rd_valid=0, rd_data=0, rd_perr=0.
  - LOAD: c = seed(idx), iter=0, then SHIFT.
  - SHIFT: applies BITS_PER_CYC iterations per cycle; after N total iterations, goes to WRITE.
  - WRITE: mem[idx]=c. If idx is last, go to DONE; otherwise idx++ and go to LOAD.
  - DONE: ready=1. IDLE is unused after reset and is reserved as a safe default in the case statement.
- Build time is depth*(N/BITS_PER_CYC+2) cycles. Defaults give 256*10 = 2560 cycles.
- Read port:
  - In DONE, rd_en=1 registers mem[rd_addr] into rd_data with rd_valid=1 on the next cycle.
  - rd_valid=0 in any cycle following no accepted read; rd_data holds its last value.
  - Back-to-back reads give one result per cycle.
- rd_en while ready=0: ignored, no rd_valid, no error.
- rebuild: in any state, on the next cycle ready=0 and the state goes to LOAD with idx=0.
  - A read accepted in the same cycle as rebuild is dropped; rd_valid stays 0.
  - rebuild during a build restarts from idx 0.
- rst mid-build or mid-read: all state returns to reset values. Memory contents are don't-care until rebuilt.
- idx wraps only through the last-entry check; it never writes beyond depth-1.

Optional Feature:
- Macro CRC_LUT_GEN_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed in WRITE.
  - Reads recompute parity; rd_perr=1 with rd_valid on mismatch. rd_data is still returned.
  - Bench hook: a hierarchical force on a memory bit must raise rd_perr.
- Undefined: no parity storage; rd_perr constant 0.

Decomposition:
- Package crc_lut_pkg:
  - FSM state enum.
  - Function crc_step(c, poly, reflect), one iteration.
  - Function seed(idx, reflect, crc_w).
  - Standard polynomial constants: CRC32_POLY_REFL = 32'hEDB88320, CRC32_POLY_NORM = 32'h04C11DB7.
- One sub-module crc_lut_ram: depth x (CRC_W[+1]) single-port-write/single-port-read RAM with registered read.
- The FSM and shift datapath stay in crc_lut_gen.

Test Plan:
- Default parameters (STAGE=0, REFLECT=1, POLY=EDB88320):
  - rst, then wait for ready.
  - ready must rise exactly 2560 cycles after rst release.
  - Reads of idx 0x01, 0x80, 0xFF return 0x77073096, 0xEDB88320, 0x2D02EF8D, each with rd_valid one cycle later.
- REFLECT=0, POLY=04C11DB7: idx 0x01 returns 0x04C11DB7 and idx 0x02 returns 0x09823B6E.
- STAGE=19, BITS_PER_CYC=8:
  - All 256 entries match a software model iterating 160 shifts.
  - Linearity holds: T[0x03] == T[0x01]^T[0x02].
- rd_en held high from reset: no rd_valid until ready. Then reads addr 0..255 back-to-back with rd_valid continuous for 256 cycles.
- rebuild pulsed mid-build (idx 100) and again in DONE together with rd_en: ready drops next cycle, the read is dropped, ready returns after a full 2560-cycle rebuild.
- With CRC_LUT_GEN_PARITY_EN: force one bit of mem[0x55], read 0x55 and expect rd_perr=1. Without the macro, rd_perr=0 throughout.
